// File: rtl/pipe_stage_ctrl.sv
// Sequencing controller for a chain of pipeline-register walls: per-stage valid
// tracking, stall propagation, bubble insertion, flush squash and refill lockout.
module pipe_stage_ctrl #(
   parameter int STAGES        = 5,
   parameter int REFILL_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [STAGES-1:0]         stall_req,
   input  logic                      flush_req,
   input  logic [$clog2(STAGES)-1:0] flush_stage,
   output logic [STAGES-1:0]         stage_en,
   output logic [STAGES-1:0]         stage_soft_reset,
   output logic [STAGES-1:0]         stage_valid,
   output logic                      refill_busy,
   output logic [CNT_W-1:0]          stall_cycles
);

   localparam int FS_W = $clog2(STAGES);
   localparam logic [FS_W-1:0] TOP_STAGE = FS_W'(STAGES - 1);
   localparam logic [3:0]      RELOAD    = 4'(REFILL_CYCLES);

   typedef enum logic {IDLE, REFILL} state_t;

   state_t             state;
   logic [3:0]         refill_cnt;
   logic [FS_W-1:0]    fs_clamped;
   logic [STAGES-1:0]  squash;
   logic [STAGES-1:0]  hold;
   logic [STAGES-1:0]  incoming;
   logic [STAGES-1:0]  valid_next;

   assign fs_clamped = (flush_stage > TOP_STAGE) ? TOP_STAGE : flush_stage;

   // Hold propagates from the oldest stage down; a squashed stage never holds,
   // and an invalid stage breaks the chain so its bubble can be overwritten.
   always_comb begin
      logic carry;
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      squash = '0;
      hold   = '0;
      carry  = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         squash[i] = flush_req & (FS_W'(i) <= fs_clamped);
      end
      for (int i = STAGES - 1; i >= 0; i--) begin
         if (squash[i]) begin
            carry = 1'b0;
         end else begin
            carry = stall_req[i] | (stage_valid[i] & carry);
         end
         hold[i] = carry;
      end
   end

   assign in_ready = ~hold[0] & (state == IDLE) & ~flush_req;

   always_comb begin
      incoming    = '0;
      valid_next  = '0;
      incoming[0] = in_valid & in_ready;
      for (int i = 1; i < STAGES; i++) begin
         incoming[i] = stage_valid[i-1] & ~hold[i-1];
      end
      for (int i = 0; i < STAGES; i++) begin
         if (squash[i])    valid_next[i] = 1'b0;
         else if (hold[i]) valid_next[i] = stage_valid[i];
         else              valid_next[i] = incoming[i];
      end
   end

   assign stage_en         = ~hold | squash;
   // Soft reset is suppressed while reset is asserted so the walls sit quiet.
   assign stage_soft_reset = reset ? (squash | (~hold & ~incoming)) : '0;
   assign refill_busy      = (state == REFILL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage_valid <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         stage_valid <= valid_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         refill_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush_req) begin
                  state      <= REFILL;
                  refill_cnt <= RELOAD;
               end
            end
            REFILL: begin
               if (flush_req) begin
                  refill_cnt <= RELOAD;
               end else if (refill_cnt <= 4'd1) begin
                  state      <= IDLE;
                  refill_cnt <= '0;
               end else begin
                  refill_cnt <= refill_cnt - 4'd1;
               end
            end
            default: begin
               state      <= IDLE;
               refill_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
      end else if (in_valid && !in_ready && !(&stall_cycles)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl: stimulus queues expected outputs per
// cycle, a monitor pops and compares them on the falling clock edge.
module tb_pipe_stage_ctrl;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  stall_req;
   logic        flush_req;
   logic [2:0]  flush_stage;
   logic [4:0]  stage_en;
   logic [4:0]  stage_soft_reset;
   logic [4:0]  stage_valid;
   logic        refill_busy;
   logic [15:0] stall_cycles;

   pipe_stage_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .stall_req        (stall_req),
      .flush_req        (flush_req),
      .flush_stage      (flush_stage),
      .stage_en         (stage_en),
      .stage_soft_reset (stage_soft_reset),
      .stage_valid      (stage_valid),
      .refill_busy      (refill_busy),
      .stall_cycles     (stall_cycles)
   );

   typedef enum logic [2:0] {S_VALID, S_EN, S_SR, S_READY, S_BUSY, S_STALL} sel_e;

   typedef struct packed {
      sel_e        sel;
      int          cyc;
      logic [15:0] mask;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int c, input logic [15:0] act,
                        input logic [15:0] want, input logic [15:0] mask);
      checks++;
      if ((act & mask) !== (want & mask)) begin
         failures++;
         $display("FAIL %s cycle %0d: got %h want %h (mask %h)", name, c, act & mask,
                  want & mask, mask);
      end
   endtask

   task automatic expect_out(input sel_e sel, input logic [15:0] val,
                             input logic [15:0] mask = 16'hFFFF);
      exp_t e;
      e.sel  = sel;
      e.cyc  = cyc;
      e.mask = mask;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic step(input logic iv, input logic [4:0] st, input logic fl,
                       input logic [2:0] fs);
      @(posedge clk);
      #1;
      cyc++;
      in_valid    = iv;
      stall_req   = st;
      flush_req   = fl;
      flush_stage = fs;
   endtask

   // Monitor: compare every expectation queued for the current cycle.
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() != 0) begin
            exp_t        e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.sel)
               S_VALID: act = {11'd0, stage_valid};
               S_EN:    act = {11'd0, stage_en};
               S_SR:    act = {11'd0, stage_soft_reset};
               S_READY: act = {15'd0, in_ready};
               S_BUSY:  act = {15'd0, refill_busy};
               default: act = stall_cycles;
            endcase
            check(e.sel.name(), e.cyc, act, e.val, e.mask);
         end
      end
   end

   initial begin
      reset       = 1'b0;
      in_valid    = 1'b0;
      stall_req   = '0;
      flush_req   = 1'b0;
      flush_stage = '0;
      #1;
      expect_out(S_VALID, 16'h00);
      expect_out(S_EN,    16'h1F);
      expect_out(S_SR,    16'h00);
      expect_out(S_READY, 16'h1);
      expect_out(S_BUSY,  16'h0);
      expect_out(S_STALL, 16'h0);
      @(negedge clk);
      #1 reset = 1'b1;

      // Single instruction walks the empty pipe.
      step(1'b1, 5'b00000, 1'b0, 3'd0);
      expect_out(S_VALID, 16'h00);
      expect_out(S_SR,    16'h1E);
      expect_out(S_EN,    16'h1F);
      expect_out(S_READY, 16'h1);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 5'b00000, 1'b0, 3'd0);
         expect_out(S_VALID, 16'(1 << k));
         expect_out(S_SR,    16'(~(2 << k) & 5'h1F));
      end
      step(1'b0, 5'b00000, 1'b0, 3'd0);
      expect_out(S_VALID, 16'h00);

      // Fill, then stall the oldest stage for three cycles.
      repeat (5) step(1'b1, 5'b00000, 1'b0, 3'd0);
      step(1'b1, 5'b10000, 1'b0, 3'd0);
      expect_out(S_VALID, 16'h1F);
      expect_out(S_EN,    16'h00);
      expect_out(S_READY, 16'h0);
      expect_out(S_STALL, 16'd0);
      step(1'b1, 5'b10000, 1'b0, 3'd0);
      expect_out(S_VALID, 16'h1F);
      step(1'b1, 5'b10000, 1'b0, 3'd0);
      expect_out(S_STALL, 16'd2);
      step(1'b1, 5'b00000, 1'b0, 3'd0);
      expect_out(S_STALL, 16'd3);
      expect_out(S_VALID, 16'h1F);
      expect_out(S_EN,    16'h1F);
      expect_out(S_SR,    16'h00);
      expect_out(S_READY, 16'h1);

      // Build 10101 and stall stage 4: the bubble in stage 3 is overwritten.
      step(1'b1, 5'b00000, 1'b0, 3'd0);
      step(1'b0, 5'b00000, 1'b0, 3'd0);
      step(1'b1, 5'b00000, 1'b0, 3'd0);
      step(1'b0, 5'b00000, 1'b0, 3'd0);
      step(1'b1, 5'b00000, 1'b0, 3'd0);
      step(1'b0, 5'b10000, 1'b0, 3'd0);
      expect_out(S_VALID, 16'h15);
      expect_out(S_EN,    16'h0F);
      expect_out(S_SR,    16'h05);
      expect_out(S_READY, 16'h1);
      step(1'b1, 5'b00000, 1'b0, 3'd0);
      expect_out(S_VALID, 16'h1A);
      repeat (4) step(1'b1, 5'b00000, 1'b0, 3'd0);

      // Flush stages 0..2 of a full pipe, then two refill cycles.
      step(1'b1, 5'b00000, 1'b1, 3'd2);
      expect_out(S_VALID, 16'h1F);
      expect_out(S_SR,    16'h07);
      expect_out(S_EN,    16'h1F);
      expect_out(S_READY, 16'h0);
      expect_out(S_BUSY,  16'h0);
      expect_out(S_STALL, 16'd3);
      step(1'b1, 5'b00000, 1'b0, 3'd0);
      expect_out(S_VALID, 16'h10, 16'h17);
      expect_out(S_BUSY,  16'h1);
      expect_out(S_READY, 16'h0);
      step(1'b1, 5'b00000, 1'b0, 3'd0);
      expect_out(S_BUSY,  16'h1);
      expect_out(S_READY, 16'h0);
      step(1'b1, 5'b00000, 1'b0, 3'd0);
      expect_out(S_BUSY,  16'h0);
      expect_out(S_READY, 16'h1);
      expect_out(S_STALL, 16'd6);

      // Out-of-range flush_stage clamps to all stages, overriding stalls;
      // a second flush in the first refill cycle extends the lockout.
      step(1'b0, 5'b11111, 1'b1, 3'd7);
      expect_out(S_SR,    16'h1F);
      expect_out(S_EN,    16'h1F);
      expect_out(S_READY, 16'h0);
      expect_out(S_BUSY,  16'h0);
      step(1'b0, 5'b00000, 1'b1, 3'd0);
      expect_out(S_VALID, 16'h00);
      expect_out(S_BUSY,  16'h1);
      step(1'b0, 5'b00000, 1'b0, 3'd0);
      expect_out(S_BUSY,  16'h1);
      step(1'b0, 5'b00000, 1'b0, 3'd0);
      expect_out(S_BUSY,  16'h1);
      expect_out(S_READY, 16'h0);
      step(1'b0, 5'b00000, 1'b0, 3'd0);
      expect_out(S_BUSY,  16'h0);
      expect_out(S_READY, 16'h1);
      expect_out(S_STALL, 16'd6);

      // Sustained stall saturates the counter.
      repeat (65600) step(1'b1, 5'b00001, 1'b0, 3'd0);
      expect_out(S_STALL, 16'hFFFF);
      expect_out(S_READY, 16'h0);
      step(1'b1, 5'b00001, 1'b0, 3'd0);
      expect_out(S_STALL, 16'hFFFF);

      // Enter REFILL, then pull reset low mid-cycle.
      step(1'b1, 5'b00000, 1'b1, 3'd0);
      step(1'b1, 5'b00000, 1'b0, 3'd0);
      expect_out(S_BUSY,  16'h1);
      expect_out(S_STALL, 16'hFFFF);
      @(posedge clk);
      #1;
      cyc++;
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      expect_out(S_VALID, 16'h00);
      expect_out(S_BUSY,  16'h0);
      expect_out(S_STALL, 16'h0);
      expect_out(S_READY, 16'h1);
      expect_out(S_SR,    16'h00);
      expect_out(S_EN,    16'h1F);
      @(negedge clk);
      #1 reset = 1'b1;

      for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending entries want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
Sequencing controller for the chain of pipeline-register walls in the in-order front/back pipe. It tracks a valid bit per stage and drives each wall's enable and softReset. This advances instructions, holds them on stall requests, inserts bubbles and squashes stages on a flush. After a flush it runs a short refill-lockout FSM and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
STAGES, 5, number of pipeline register walls controlled (stage 0 = youngest, STAGES-1 = oldest)
REFILL_CYCLES, 2, cycles in_ready stays low after a flush (1..15)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
in_valid  input  1  upstream presents an instruction to stage 0
in_ready  output  1  controller accepts in_valid this cycle
stall_req  input  STAGES  bit i: stage i cannot advance this cycle
flush_req  input  1  squash request (e.g. mispredict)
flush_stage  input  $clog2(STAGES)  highest stage index squashed; stages 0..flush_stage cleared
stage_en  output  STAGES  enable to wall i
stage_soft_reset  output  STAGES  softReset to wall i
stage_valid  output  STAGES  registered valid bit per stage
refill_busy  output  1  high while FSM in REFILL
stall_cycles  output  CNT_W  saturating count of cycles with in_valid=1 and in_ready=0

Behaviour:
- Reset (reset=0, async): stage_valid=0, FSM=IDLE, refill counter=0, stall_cycles=0. Outputs settle to stage_en=all 1, stage_soft_reset=0, refill_busy=0, in_ready=1.
- hold[] (combinational, oldest first):
  - hold[STAGES-1] = stall_req[STAGES-1].
  - hold[i] = stall_req[i] | (stage_valid[i] & hold[i+1]).
  - An invalid stage never blocks: a bubble is overwritten even when the stage above holds.
- stage_en[i] = ~hold[i], except a flushed stage, where stage_en=1.
- incoming[i]:
  - incoming[0] = in_valid & in_ready.
  - incoming[i] = stage_valid[i-1] & ~hold[i-1].
- Next valid:
  - If hold[i]: stage_valid[i] is unchanged.
  - Otherwise: stage_valid[i] <= incoming[i].
- Bubble: stage_soft_reset[i]=1 when ~hold[i] & ~incoming[i], so an advancing stage with no producer loads zeros. Latency through the pipe is 1 cycle per stage with no stalls.
- in_ready = ~hold[0] & (FSM==IDLE) & ~flush_req.
- Flush:
  - With flush_req=1 in any state, for stages i<=flush_stage: stage_soft_reset[i]=1 and stage_en[i]=1 (softReset wins in the wall), and stage_valid[i] <= 0 at the edge.
  - Stages above flush_stage follow normal rules, and hold[] for them ignores squashed stages below.
  - flush_stage >= STAGES is clamped to STAGES-1.
- FSM (IDLE, REFILL):
  - IDLE --flush_req--> REFILL, with cnt <= REFILL_CYCLES.
  - REFILL: cnt decrements each cycle and goes to IDLE when cnt reaches 1. A flush_req in REFILL reloads cnt to REFILL_CYCLES and stays in REFILL.
  - refill_busy = (FSM==REFILL). in_ready=0 throughout REFILL.
- Simultaneous events:
  - flush_req overrides stall_req for squashed stages.
  - in_valid during a flush is not accepted (in_ready=0).
- stall_cycles increments when in_valid & ~in_ready, and saturates at 2^CNT_W-1 with no wrap.
- Reset asserted mid-flush or mid-stall returns everything to reset values on the same edge/asynchronously. No pending flush survives reset.

Test Plan:
- Reset, then in_valid=1 for 1 cycle, no stalls -> stage_valid walks 00001,00010,...,10000 over 5 cycles; stage_soft_reset=1 on each invalid advancing stage.
- Pipe full (stage_valid=11111), stall_req=10000 for 3 cycles with in_valid=1 -> stage_en=00000, in_ready=0, stage_valid stays 11111, stall_cycles goes 0->3. Release -> all advance next cycle.
- stage_valid=10101, stall_req=10000 -> stage 3 (invalid) is overwritten by stage 2; stage_en=01111; next stage_valid=11010 with in_valid=0.
- stage_valid=11111, flush_req=1, flush_stage=2 -> stage_soft_reset=00111; next stage_valid has bits[2:0]=0; refill_busy=1 for exactly 2 cycles; in_ready=0 during flush and both refill cycles.
- Second flush_req in the 1st REFILL cycle -> refill_busy extends to 2 cycles after the second flush (3 total).
- Drive stall_cycles to 16'hFFFF with a sustained stall -> it holds 16'hFFFF. Pull reset low mid-REFILL -> immediately stage_valid=0, refill_busy=0, stall_cycles=0, in_ready=1.
